// File: rtl/demux_buf.sv
// demux_buf: registered 1-to-2 demultiplexer with a small FIFO per output.
// Each accepted word is steered by in_sel into queue A (0) or queue B (1).
// Each queue drains through its own valid/ready port, so a stalled consumer
// never blocks or reorders the other queue.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data/in_sel      word to route and its destination queue
//   in_valid/in_ready   producer handshake (ready reflects the selected queue)
//   a_data/a_valid/a_ready, b_data/b_valid/b_ready   per-queue drain ports
//   a_count, b_count    current occupancy of each queue
module demux_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           a_data,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [WIDTH-1:0]           b_data,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [$clog2(DEPTH+1)-1:0] a_count,
  output logic [$clog2(DEPTH+1)-1:0] b_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NQ = 2;

  // Per-queue state, index 0 = A, index 1 = B
  logic [WIDTH-1:0] mem_q [NQ][DEPTH];
  logic [PW-1:0]    wr_q  [NQ];
  logic [PW-1:0]    wr_d  [NQ];
  logic [PW-1:0]    rd_q  [NQ];
  logic [PW-1:0]    rd_d  [NQ];
  logic [CW-1:0]    cnt_q [NQ];
  logic [CW-1:0]    cnt_d [NQ];
  logic [NQ-1:0]    push;
  logic [NQ-1:0]    pop;
  logic [NQ-1:0]    not_full;

  // Ready depends only on in_sel and registered counts, never on in_valid
  always_comb begin
    not_full[0] = (cnt_q[0] < CW'(DEPTH));
    not_full[1] = (cnt_q[1] < CW'(DEPTH));
    in_ready    = in_sel ? not_full[1] : not_full[0];
  end

  // Output view of each queue head; data is forced to zero when empty
  always_comb begin
    a_count = cnt_q[0];
    b_count = cnt_q[1];
    a_valid = (cnt_q[0] != '0);
    b_valid = (cnt_q[1] != '0);
    a_data  = a_valid ? mem_q[0][rd_q[0]] : '0;
    b_data  = b_valid ? mem_q[1][rd_q[1]] : '0;
  end

  // Handshake decode
  always_comb begin
    push[0] = in_valid && in_ready && !in_sel;
    push[1] = in_valid && in_ready &&  in_sel;
    pop[0]  = a_valid && a_ready;
    pop[1]  = b_valid && b_ready;
  end

  // Next-state pointers and counts; power-of-two DEPTH makes pointers wrap naturally
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      wr_d[q]  = wr_q[q];
      rd_d[q]  = rd_q[q];
      cnt_d[q] = cnt_q[q];
      if (push[q]) wr_d[q] = wr_q[q] + PW'(1);
      if (pop[q])  rd_d[q] = rd_q[q] + PW'(1);
      case ({push[q], pop[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + CW'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - CW'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase
    end
  end

  // Control registers; reset wins over any concurrent push or pop
  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (rst) begin
        wr_q[q]  <= '0;
        rd_q[q]  <= '0;
        cnt_q[q] <= '0;
      end else begin
        wr_q[q]  <= wr_d[q];
        rd_q[q]  <= rd_d[q];
        cnt_q[q] <= cnt_d[q];
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (push[q] && !rst) mem_q[q][wr_q[q]] <= in_data;
    end
  end

endmodule

// File: tb/tb_demux_buf.sv
module tb_demux_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  a_count;
  logic [1:0]  b_count;

  int n_cmp = 0;
  int n_err = 0;

  demux_buf #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd77; in_sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;

    // Reset held two cycles with in_valid high: nothing may be pushed
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    chk("rst_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1; #1;
    chk("rst_ready_sel1", 32'(in_ready), 32'd1);

    // Basic routing
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd100;
    step();
    chk("route_a_data", a_data, 32'd100);
    chk("route_a_valid", 32'(a_valid), 32'd1);
    chk("route_a_count", 32'(a_count), 32'd1);
    chk("route_b_valid0", 32'(b_valid), 32'd0);
    in_sel = 1'b1; in_data = 32'd50;
    step();
    in_valid = 1'b0;
    chk("route_b_data", b_data, 32'd50);
    chk("route_b_count", 32'(b_count), 32'd1);
    chk("route_a_count2", 32'(a_count), 32'd1);
    chk("route_a_data2", a_data, 32'd100);

    // Drain both to start the fill test from empty
    a_ready = 1'b1; b_ready = 1'b1;
    step();
    a_ready = 1'b0; b_ready = 1'b0;
    chk("drain_a_count", 32'(a_count), 32'd0);
    chk("drain_b_count", 32'(b_count), 32'd0);

    // Fill A and stall
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd23;
    step();
    in_data = 32'd99;
    step();
    chk("fill_a_count", 32'(a_count), 32'd2);
    chk("fill_ready_sel0", 32'(in_ready), 32'd0);
    in_data = 32'd55;   // offered while full: must be ignored
    step();
    chk("full_a_count", 32'(a_count), 32'd2);
    chk("full_a_head", a_data, 32'd23);
    in_sel = 1'b1; #1;
    chk("full_ready_sel1", 32'(in_ready), 32'd1);
    in_data = 32'd7;
    step();
    in_valid = 1'b0;
    chk("fill_b_data", b_data, 32'd7);
    chk("fill_b_count", 32'(b_count), 32'd1);
    chk("fill_a_count_kept", 32'(a_count), 32'd2);

    // Drain order
    a_ready = 1'b1;
    chk("drain_head0", a_data, 32'd23);
    step();
    chk("drain_head1", a_data, 32'd99);
    chk("drain_count1", 32'(a_count), 32'd1);
    step();
    a_ready = 1'b0;
    chk("drain_a_valid", 32'(a_valid), 32'd0);
    chk("drain_a_data0", a_data, 32'd0);
    in_sel = 1'b0; #1;
    chk("drain_ready_sel0", 32'(in_ready), 32'd1);
    chk("drain_b_untouched", b_data, 32'd7);

    // Concurrent push/pop with pointer wrap
    in_valid = 1'b1; in_data = 32'd1;
    step();
    chk("cc_prime_head", a_data, 32'd1);
    a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'(5 + i);
      step();
      chk("cc_count", 32'(a_count), 32'd1);
      chk("cc_data", a_data, 32'(5 + i));
    end
    in_valid = 1'b0;
    step();
    a_ready = 1'b0;
    chk("cc_empty", 32'(a_count), 32'd0);

    // Reset mid-operation: A=2, B=1 (7 still queued)
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd10;
    step();
    in_data = 32'd11;
    step();
    in_valid = 1'b0;
    chk("mid_a_count", 32'(a_count), 32'd2);
    chk("mid_b_count", 32'(b_count), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_a_count", 32'(a_count), 32'd0);
    chk("mid_rst_b_count", 32'(b_count), 32'd0);
    chk("mid_rst_b_valid", 32'(b_valid), 32'd0);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'd42;
    step();
    in_valid = 1'b0;
    chk("post_rst_b_data", b_data, 32'd42);
    chk("post_rst_b_count", 32'(b_count), 32'd1);
    chk("post_rst_a_count", 32'(a_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
